sdr_16_sched: RTL
=================

SDR_16_SCHED -- requirements
Module: sdr_16_sched

Interface
REQ-001 Parameter nr_of_ports, default 4: number of requesters sharing the SDRAM controller (fixed at 4 in this release).
REQ-002 Parameter rfr_interval, default 16'd780: sdram_clk cycles between refresh ticks (7.8 us at 100 MHz).
REQ-003 Parameter rfr_max, default 4'd8: maximum postponed refreshes.
REQ-004 sdram_clk  in  1  single clock; all logic on its rising edge.
REQ-005 sdram_rst  in  1  synchronous, active-high reset.
REQ-006 req  in  4  per-port request; held by the port until served.
REQ-007 done  in  1  one-cycle pulse from the controller when the granted transaction completes.
REQ-008 state_idle  in  1  controller FSM is in idle.
REQ-009 cmd_aref  in  1  one-cycle refresh-command pulse from the controller (refresh ack).
REQ-010 gnt  out  4  one-hot grant, registered.
REQ-011 refresh_req  out  1  refresh request to the controller, registered.
REQ-012 rfr_pending  out  4  postponed-refresh count, registered.
REQ-013 rfr_overflow  out  1  sticky error: tick arrived with rfr_pending==rfr_max.

Function
REQ-014 States: INIT, ARB, BUSY, RFR; all outputs are driven from registers only.
REQ-015 INIT: gnt=0 and refresh_req=0; move to ARB on the first cycle state_idle=1; cmd_aref is ignored in INIT.
REQ-016 Refresh timer: 16-bit down counter loaded with rfr_interval-1; counting starts at reset release independent of state; at 0 it emits a one-cycle tick and reloads.
REQ-017 rfr_pending: +1 on tick; -1 on cmd_aref outside INIT; unchanged when both occur in the same cycle; never below 0.
REQ-018 On tick with rfr_pending==rfr_max: count saturates, rfr_overflow <= 1 until reset.
REQ-019 ARB priority 1: rfr_pending==rfr_max -> RFR, regardless of req.
REQ-020 ARB priority 2: any req bit set -> BUSY; gnt is loaded with the first set bit searched round-robin starting at (last+1) mod 4; last is a 2-bit register, reset value 3 (port 0 has first priority).
REQ-021 ARB priority 3: rfr_pending!=0 and req==0 -> RFR.
REQ-022 ARB otherwise: stay in ARB.
REQ-023 gnt is visible the cycle after the ARB decision and stays constant throughout BUSY, even if the granted req drops.
REQ-024 BUSY: on done, gnt <= 0, last <= granted index, next state ARB; at least one ARB cycle separates consecutive grants.
REQ-025 done outside BUSY is ignored.
REQ-026 RFR: refresh_req=1 from the cycle after entry; on cmd_aref, refresh_req <= 0 and next state ARB.
REQ-027 Refresh postponement: pending refreshes are served only when no request is present, unless the count is at rfr_max.
REQ-028 refresh_req and gnt are never both nonzero.

Reset
REQ-029 When sdram_rst=1 at a clock edge: state=INIT, gnt=4'b0000, refresh_req=0, rfr_pending=0, rfr_overflow=0, last=3, timer=rfr_interval-1.
REQ-030 Reset takes priority over every other event, including mid-BUSY or mid-RFR; no grant or request survives reset.

Verification
REQ-031 Reset, state_idle=0 for 20 cycles, req=4'b1111 -> gnt stays 0 until state_idle=1; then gnt=4'b0001.
REQ-032 req=4'b1111 held, done pulsed after each grant -> gnt sequence 0001, 0010, 0100, 1000, 0001, with exactly one gnt=0 cycle between grants.
REQ-033 rfr_interval=10, req=0 -> rfr_pending=1 at cycle 10 and refresh_req=1; cmd_aref pulse -> rfr_pending=0, refresh_req=0, state ARB.
REQ-034 rfr_interval=10, req=4'b0001 held, done never pulsed -> after 8 ticks rfr_pending=8; after done -> RFR is entered even though req is set; a 9th tick before the ack sets rfr_overflow=1 with rfr_pending held at 8.
REQ-035 Tick and cmd_aref in the same cycle with rfr_pending=3 -> rfr_pending stays 3.
REQ-036 sdram_rst asserted during BUSY with gnt=0100 -> next cycle gnt=0, state INIT, rfr_pending=0; after reset release and state_idle=1, port 0 is granted first.

Source files
------------

// File: rtl/sdr_16_sched_if.sv
// Handshake bundle between the SDRAM command scheduler and its environment:
// port requests and controller status in, grant/refresh control out.
interface sdr_16_sched_if;
   logic [3:0] req;
   logic       done;
   logic       state_idle;
   logic       cmd_aref;
   logic [3:0] gnt;
   logic       refresh_req;
   logic [3:0] rfr_pending;
   logic       rfr_overflow;

   // Requester/controller side: drives requests and controller status.
   modport master (
      output req, done, state_idle, cmd_aref,
      input  gnt, refresh_req, rfr_pending, rfr_overflow
   );

   // Scheduler side.
   modport slave (
      input  req, done, state_idle, cmd_aref,
      output gnt, refresh_req, rfr_pending, rfr_overflow
   );
endinterface

// File: rtl/sdr_16_sched.sv
// SDRAM access scheduler: round-robin grant among four ports, with refresh
// ticks postponed while ports are busy, up to rfr_max outstanding.
//
// state | meaning
// INIT  | waiting for the controller to report idle; no grant, no refresh
// ARB   | one-cycle decision point between grants / refreshes
// BUSY  | one port granted, waiting for done
// RFR   | refresh requested, waiting for cmd_aref
module sdr_16_sched #(
   parameter int          nr_of_ports  = 4,
   parameter logic [15:0] rfr_interval = 16'd780,
   parameter logic [3:0]  rfr_max      = 4'd8
) (
   input logic          sdram_clk,
   input logic          sdram_rst,
   sdr_16_sched_if.slave bus
);

   localparam int last_w = $clog2(nr_of_ports);

   typedef enum logic [1:0] {
      INIT = 2'd0,
      ARB  = 2'd1,
      BUSY = 2'd2,
      RFR  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          gnt_q, gnt_d;
   logic [last_w-1:0]   gidx_q, gidx_d;
   logic [last_w-1:0]   last_q, last_d;
   logic                refresh_req_q, refresh_req_d;
   logic [3:0]          pend_q, pend_d;
   logic                ovf_q, ovf_d;
   logic [15:0]         timer_q, timer_d;

   logic                tick;
   logic                ack;
   logic                pick_vld;
   logic [last_w-1:0]   pick_idx;

   assign tick = (timer_q == 16'd0);
   // An ack only counts once the controller has left its init phase.
   assign ack  = bus.cmd_aref && (state_q != INIT);

   // Refresh interval timer: free-running down counter, reload on terminal count.
   always_comb begin
      timer_d = tick ? (rfr_interval - 16'd1) : (timer_q - 16'd1);
   end

   // Postponed-refresh bookkeeping; a tick and an ack together cancel out.
   always_comb begin
      pend_d = pend_q;
      ovf_d  = ovf_q;
      if (tick && !ack) begin
         if (pend_q == rfr_max) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pend_q + 4'd1;
         end
      end else if (ack && !tick) begin
         if (pend_q != 4'd0) begin
            pend_d = pend_q - 4'd1;
         end
      end
   end

   // Round-robin search starting one past the last served port; the
   // descending loop lets the smallest offset win.
   always_comb begin
      logic [last_w-1:0] cand;
      cand     = '0;
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int i = nr_of_ports; i >= 1; i--) begin
         cand = last_q + last_w'(i);
         if (bus.req[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   // Scheduler FSM next-state and registered output values.
   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt_q;
      gidx_d        = gidx_q;
      last_d        = last_q;
      refresh_req_d = refresh_req_q;
      case (state_q)
         INIT: begin
            gnt_d         = 4'b0000;
            refresh_req_d = 1'b0;
            if (bus.state_idle) begin
               state_d = ARB;
            end
         end
         ARB: begin
            if (pend_q == rfr_max) begin
               state_d       = RFR;
               refresh_req_d = 1'b1;
            end else if (pick_vld) begin
               state_d = BUSY;
               gnt_d   = 4'b0001 << pick_idx;
               gidx_d  = pick_idx;
            end else if (pend_q != 4'd0) begin
               state_d       = RFR;
               refresh_req_d = 1'b1;
            end
         end
         BUSY: begin
            if (bus.done) begin
               gnt_d   = 4'b0000;
               last_d  = gidx_q;
               state_d = ARB;
            end
         end
         RFR: begin
            if (bus.cmd_aref) begin
               refresh_req_d = 1'b0;
               state_d       = ARB;
            end
         end
         default: begin
            state_d       = INIT;
            gnt_d         = 4'b0000;
            refresh_req_d = 1'b0;
         end
      endcase
   end

   // All state registers; reset overrides everything, including mid-transaction.
   always_ff @(posedge sdram_clk) begin
      if (sdram_rst) begin
         state_q       <= INIT;
         gnt_q         <= 4'b0000;
         gidx_q        <= '0;
         last_q        <= '1;
         refresh_req_q <= 1'b0;
         pend_q        <= 4'd0;
         ovf_q         <= 1'b0;
         timer_q       <= rfr_interval - 16'd1;
      end else begin
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         gidx_q        <= gidx_d;
         last_q        <= last_d;
         refresh_req_q <= refresh_req_d;
         pend_q        <= pend_d;
         ovf_q         <= ovf_d;
         timer_q       <= timer_d;
      end
   end

   assign bus.gnt          = gnt_q;
   assign bus.refresh_req  = refresh_req_q;
   assign bus.rfr_pending  = pend_q;
   assign bus.rfr_overflow = ovf_q;

endmodule
